// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per clock, on-the-fly key expansion.
// Optional block counter port blk_cnt_o when AES_ITER_PERF_CNT_EN is defined.
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        data_i,
    input  logic [KEY_BITS-1:0] key_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        data_o
`ifdef AES_ITER_PERF_CNT_EN
    ,
    output logic [31:0]         blk_cnt_o
`endif
);

    localparam int NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR4 = 4'(NR);

    if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = a;
        p = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]}
                 ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Four chained word XORs producing the next 128-bit key half
    function automatic logic [127:0] expand(input logic [127:0] b, input logic [31:0] t);
        logic [31:0] n0, n1, n2, n3;
        n0 = b[127:96] ^ t;
        n1 = b[95:64]  ^ n0;
        n2 = b[63:32]  ^ n1;
        n3 = b[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return o ^ rk;
    endfunction

    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [KEY_BITS-1:0] kw_q, kw_d;
    logic [3:0]          round_q, round_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [127:0]        dout_q, dout_d;

    logic [127:0]        rk;
    logic [KEY_BITS-1:0] kw_nxt;
    logic                rc_adv;
    logic [127:0]        rnd;

    if (KEY_BITS == 256) begin : g_k256
        logic [31:0]  sw;
        logic [31:0]  tw;
        logic [127:0] nw;
        // Even rounds rebuild the upper half, odd rounds the lower half
        always_comb begin
            sw     = sub_word(round_q[0] ? kw_q[159:128] : kw_q[31:0]);
            tw     = round_q[0] ? sw : ({sw[23:0], sw[31:24]} ^ {rcon_q, 24'h0});
            nw     = expand(round_q[0] ? kw_q[127:0] : kw_q[255:128], tw);
            rk     = (round_q == 4'd1) ? kw_q[127:0] : nw;
            kw_nxt = kw_q;
            rc_adv = 1'b0;
            if (round_q != 4'd1) begin
                if (round_q[0]) begin
                    kw_nxt[127:0] = nw;
                end else begin
                    kw_nxt[255:128] = nw;
                    rc_adv          = 1'b1;
                end
            end
        end
    end else begin : g_k128
        logic [31:0] sw;
        logic [31:0] tw;
        // Whole 128-bit window advances every round
        always_comb begin
            sw     = sub_word(kw_q[31:0]);
            tw     = {sw[23:0], sw[31:24]} ^ {rcon_q, 24'h0};
            kw_nxt = expand(kw_q, tw);
            rk     = kw_nxt;
            rc_adv = 1'b1;
        end
    end

    assign in_ready_o  = rst_ni && (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign data_o      = dout_q;

    // Next-state and datapath update for the round sequencer
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        kw_d    = kw_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        dout_d  = dout_q;
        rnd     = aes_round(st_q, rk, round_q == NR4);
        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    st_d    = data_i ^ key_i[KEY_BITS-1 -: 128];
                    kw_d    = key_i;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d    = rnd;
                kw_d    = kw_nxt;
                round_d = round_q + 4'd1;
                if (rc_adv) rcon_d = xt(rcon_q);
                if (round_q == NR4) begin
                    dout_d  = rnd;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            st_q    <= '0;
            kw_q    <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            kw_q    <= kw_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            dout_q  <= dout_d;
        end
    end

`ifdef AES_ITER_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Saturating count of output handshakes
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_o && out_ready_i && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign blk_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances against a FIPS-197 style model.
// Optional counter checks when AES_ITER_PERF_CNT_EN is defined.
module tb_aes_iter_core;

    logic         clk_i = 1'b0;
    logic         rst_n;

    logic         a_v, a_ir, a_ov, a_rdy;
    logic [127:0] a_d, a_do;
    logic [127:0] a_k;
    logic         b_v, b_ir, b_ov, b_rdy;
    logic [127:0] b_d, b_do;
    logic [255:0] b_k;
`ifdef AES_ITER_PERF_CNT_EN
    logic [31:0]  a_cnt, b_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int exp_a  = 0;
    int exp_b  = 0;

    logic [7:0] sb [256];

    always #5 clk_i = ~clk_i;

    aes_iter_core #(.KEY_BITS(128)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_n),
        .in_valid_i(a_v), .in_ready_o(a_ir),
        .data_i(a_d), .key_i(a_k),
        .out_valid_o(a_ov), .out_ready_i(a_rdy),
        .data_o(a_do)
`ifdef AES_ITER_PERF_CNT_EN
        , .blk_cnt_o(a_cnt)
`endif
    );

    aes_iter_core #(.KEY_BITS(256)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_n),
        .in_valid_i(b_v), .in_ready_o(b_ir),
        .data_i(b_d), .key_i(b_k),
        .out_valid_o(b_ov), .out_ready_i(b_rdy),
        .data_o(b_do)
`ifdef AES_ITER_PERF_CNT_EN
        , .blk_cnt_o(b_cnt)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int m);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box table generated by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Textbook cipher: full key schedule first, then NR rounds on a byte array
    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [255:0] key,
                                             input int           kb);
        logic [31:0]  w [60];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] o;
        int           nk, nr;
        int           mx [4][4];
        mx = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        nk = kb / 32;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    if (r == nr) begin
                        s[4*c+row] = t[4*c+row];
                    end else begin
                        s[4*c+row] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[4*c+row] = s[4*c+row] ^ gm(t[4*c+k], mx[row][k]);
                    end
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input bit wide, input logic v, input logic [127:0] d,
                         input logic [255:0] k);
        if (!wide) begin
            a_v = v; a_d = d; a_k = k[255:128];
        end else begin
            b_v = v; b_d = d; b_k = k;
        end
    endtask

    function automatic logic ov(input bit wide);
        return wide ? b_ov : a_ov;
    endfunction

    function automatic logic ir(input bit wide);
        return wide ? b_ir : a_ir;
    endfunction

    function automatic logic [127:0] dout(input bit wide);
        return wide ? b_do : a_do;
    endfunction

    function automatic void set_rdy(input bit wide, input logic r);
        if (wide) b_rdy = r;
        else      a_rdy = r;
    endfunction

    // One block: accept, wait, stall for 'stall' cycles, then hand shake.
    // lat counts clock edges from acceptance to the edge that first samples out_valid_o=1.
    task automatic run_block(input bit wide, input logic [127:0] d, input logic [255:0] k,
                             input int stall, output logic [127:0] res, output int lat);
        logic [127:0] held;
        chk("in_ready_idle", ir(wide), 1'b1);
        drive(wide, 1'b1, d, k);
        set_rdy(wide, 1'b0);
        step();
        drive(wide, 1'b0, rnd128(), {rnd128(), rnd128()});
        lat = 1;
        while (!ov(wide) && lat < 40) begin
            step();
            lat++;
            drive(wide, $urandom_range(0, 1), rnd128(), {rnd128(), rnd128()});
            set_rdy(wide, 1'b1);
            #1;
            set_rdy(wide, 1'b0);
        end
        drive(wide, 1'b0, '0, '0);
        chk("out_valid_timeout", ov(wide), 1'b1);
        held = dout(wide);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", ov(wide), 1'b1);
            chk("stall_data", dout(wide), held);
            chk("stall_in_ready", ir(wide), 1'b0);
        end
        res = dout(wide);
        set_rdy(wide, 1'b1);
        step();
        set_rdy(wide, 1'b0);
        if (wide) exp_b++;
        else      exp_a++;
        chk("valid_drop", ov(wide), 1'b0);
        chk("ready_back", ir(wide), 1'b1);
    endtask

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] K_C3  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] d1, d2;
        logic [255:0] k1, k2;
        int           lat;
        int           bad;

        build_sbox();
        rst_n = 1'b0;
        a_v = 0; a_d = '0; a_k = '0; a_rdy = 0;
        b_v = 0; b_d = '0; b_k = '0; b_rdy = 0;

        // reset state
        step();
        step();
        chk("rst_in_ready_a", a_ir, 1'b0);
        chk("rst_in_ready_b", b_ir, 1'b0);
        chk("rst_out_valid_a", a_ov, 1'b0);
        chk("rst_out_valid_b", b_ov, 1'b0);
        chk("rst_data_a", a_do, 128'h0);
        chk("rst_data_b", b_do, 128'h0);
`ifdef AES_ITER_PERF_CNT_EN
        chk("rst_cnt_a", a_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        #1;

        // FIPS-197 C.1, no stall
        run_block(1'b0, PT_C, K_C1, 0, res, lat);
        chk("c1_data", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("c1_latency", lat, 11);

        // FIPS-197 appendix B with 5-cycle output stall
        run_block(1'b0, PT_B, K_B, 5, res, lat);
        chk("b_data", res, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("b_latency", lat, 11);

        // FIPS-197 C.3, AES-256
        run_block(1'b1, PT_C, K_C3, 1, res, lat);
        chk("c3_data", res, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("c3_latency", lat, 15);

        // back-to-back with in_valid_i held high and inputs toggling during RUN
        d1 = rnd128();
        k1 = {rnd128(), rnd128()};
        drive(1'b0, 1'b1, d1, k1);
        a_rdy = 1'b1;
        step();
        lat = 1;
        while (!a_ov && lat < 40) begin
            drive(1'b0, 1'b1, rnd128(), {rnd128(), rnd128()});
            step();
            lat++;
        end
        chk("b2b_lat1", lat, 11);
        chk("b2b_data1", a_do, aes_ref(d1, k1, 128));
        d2 = rnd128();
        k2 = {rnd128(), rnd128()};
        drive(1'b0, 1'b1, d2, k2);
        step();
        exp_a++;
        chk("b2b_valid_drop", a_ov, 1'b0);
        chk("b2b_ready_after_hs", a_ir, 1'b1);
        step();
        drive(1'b0, 1'b0, rnd128(), {rnd128(), rnd128()});
        chk("b2b_accepted_second", a_ir, 1'b0);
        lat = 1;
        while (!a_ov && lat < 40) begin
            step();
            lat++;
        end
        chk("b2b_lat2", lat, 11);
        chk("b2b_data2", a_do, aes_ref(d2, k2, 128));
        step();
        exp_a++;
        a_rdy = 1'b0;
        chk("b2b_idle", a_ir, 1'b1);

        // reset while round counter is 5
        drive(1'b0, 1'b1, rnd128(), {rnd128(), rnd128()});
        step();
        drive(1'b0, 1'b0, '0, '0);
        a_rdy = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", a_ir, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        exp_a = 0;
        exp_b = 0;
        chk("mid_rst_valid", a_ov, 1'b0);
        chk("mid_rst_idle", a_ir, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_ov) bad++;
        end
        chk("mid_rst_no_output", bad, 0);
        a_rdy = 1'b0;
        run_block(1'b0, PT_C, K_C1, 0, res, lat);
        chk("post_rst_c1", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // randomized blocks on both key sizes
        for (int i = 0; i < 8; i++) begin
            d1 = rnd128();
            k1 = {rnd128(), rnd128()};
            run_block(i[0], d1, k1, $urandom_range(0, 3), res, lat);
            chk(i[0] ? "rand256_data" : "rand128_data", res,
                aes_ref(d1, k1, i[0] ? 256 : 128));
            chk("rand_latency", lat, i[0] ? 15 : 11);
        end

`ifdef AES_ITER_PERF_CNT_EN
        chk("cnt_a", a_cnt, 32'(exp_a));
        chk("cnt_b", b_cnt, 32'(exp_b));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("cnt_a_reset", a_cnt, 32'd0);
        chk("cnt_b_reset", b_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
